logic_op_sequencer: RTL
=======================

Name: logic_op_sequencer

Overview:
- Command-side initiator and result collector for the ALU logic path. Buffers AND/OR/XOR requests in a small FIFO and executes them one per cycle.
- Each result is presented through a valid/ready response port. Command order is preserved.
- Keeps a WIDTH-bit accumulator so chained logic operations can run without the host round-tripping operands.
- Sits between the ALU control front end and the logic datapath.

Parameters:
- WIDTH, 4, operand width in bits.
- DEPTH, 4, command FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_sel  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 illegal.
- cmd_acc  input  1  1 = use the accumulator as operand A; cmd_a is ignored.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- rsp_valid  output  1  response held in the output register.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  2*WIDTH  result; upper WIDTH bits are always 0.
- rsp_err  output  1  response came from an illegal sel.
- acc  output  WIDTH  current accumulator value.
- busy  output  1  FIFO non-empty or rsp_valid high.

Behaviour:
- Reset: all of the following happen on the first rising edge with rst=1, overriding any simultaneous handshake.
  - FIFO pointers and count go to 0.
  - rsp_valid=0, rsp_result=0, rsp_err=0, acc=0, busy=0.
  - cmd_ready=1 in the cycle after reset.
  - Reset mid-operation discards all queued and pending responses.
- Command accept: on a clock edge where cmd_valid && cmd_ready.
  - The entry {sel, acc_flag, a, b} is written at the write pointer.
  - cmd_ready = (count != DEPTH). It depends on registered state only, not on a same-cycle pop.
  - cmd_valid while full is ignored; no overflow, no state change.
- Execute: a pop occurs on an edge where the FIFO is non-empty and (!rsp_valid || rsp_ready).
  - The popped entry is computed and loaded into the output register: rsp_valid=1, rsp_result, rsp_err.
  - If the FIFO is empty and rsp_valid && rsp_ready, rsp_valid clears.
  - If rsp_valid && !rsp_ready, the output register holds stable: rsp_result and rsp_err do not change and no pop occurs.
- Operand A = acc_flag ? acc : a. Result = {WIDTH zeros, A op B}.
- Illegal sel 11: rsp_result=0, rsp_err=1, acc unchanged.
- Accumulator: on each legal pop, acc <= low WIDTH bits of the result. acc is read at pop time, so it always reflects every earlier command in order.
- Latency: a command accepted at edge k into an empty FIFO with a free output register gives rsp_valid=1 after edge k+1. Throughput is 1 response per cycle while rsp_ready=1.
- Simultaneous push and pop: count unchanged. Push into an empty FIFO plus a pop on the same edge is impossible; the entry pops on the next eligible edge.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- busy = (count != 0) || rsp_valid.

Test Plan:
- Reset, then accept AND a=4'hC b=4'hA, rsp_ready=1 -> rsp_valid after edge k+1, rsp_result=8'h08, rsp_err=0, acc=4'h8.
- Chain: OR a=4'h1 b=4'h2, then XOR cmd_acc=1 b=4'hF, then AND cmd_acc=1 b=4'h6:
  - results are 8'h03, 8'h0C, 8'h04 in order;
  - final acc=4'h4.
- Backpressure: rsp_ready=0, issue DEPTH+2 commands.
  - After DEPTH+1 accepts (4 in FIFO, 1 in the output register) cmd_ready=0 and the extra command is dropped.
  - rsp_result holds stable while rsp_ready=0.
  - Raising rsp_ready drains 5 responses in 5 consecutive cycles, in order.
- Illegal sel=11 with a=4'hF b=4'hF after acc=4'h5 -> rsp_err=1, rsp_result=0, acc stays 4'h5. The next legal command gives rsp_err=0.
- Wrap-around: stream 3*DEPTH commands with rsp_ready toggling every cycle -> no loss, no duplication, order preserved.
- Assert rst with 3 entries queued and rsp_valid=1 -> the next cycle shows rsp_valid=0, busy=0, acc=0, cmd_ready=1, and no stale response appears afterwards.

Source files
------------

// File: rtl/logic_op_sequencer.sv
// Queues AND/OR/XOR commands and executes one per cycle into a registered response; result one edge after accept.
// Backpressure: a held response stalls the FIFO head; cmd_ready drops only when all DEPTH entries are occupied.
module logic_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_sel,
    input  logic               cmd_acc,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_err,
    output logic [WIDTH-1:0]   acc,
    output logic               busy
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef struct packed {
        logic [1:0]       sel;
        logic             acc_flag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    entry_t           head;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] alu_res;
    logic             illegal;

    // cmd_ready looks only at registered occupancy, never at a same-cycle pop
    assign cmd_ready = (count != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (count != '0) && (!rsp_valid || rsp_ready);
    assign busy      = (count != '0) || rsp_valid;
    assign head      = mem[rd_ptr];
    assign op_a      = head.acc_flag ? acc : head.a;

    always_comb begin
        alu_res = '0;
        illegal = 1'b0;
        case (head.sel)
            2'b00:   alu_res = op_a & head.b;
            2'b01:   alu_res = op_a | head.b;
            2'b10:   alu_res = op_a ^ head.b;
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= '{sel: cmd_sel, acc_flag: cmd_acc, a: cmd_a, b: cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            acc        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                rsp_valid  <= 1'b1;
                rsp_result <= {{WIDTH{1'b0}}, alu_res};
                rsp_err    <= illegal;
                if (!illegal) begin
                    acc <= alu_res;
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
